// File: rtl/ifetch_unit.sv
// RV32I instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction ROM,
// and applies stalls, branch/JAL/JALR redirects and misaligned-target traps.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   br_taken,
  input  logic                   jal,
  input  logic                   jalr,
  input  logic [31:0]            imm32,
  input  logic [31:0]            rs1_data,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            inst,
  output logic                   inst_valid,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   misalign,
  output logic [31:0]            inst_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] target;
  logic        redirect;
  logic        target_misaligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LOAD;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
    end
  end

  // JALR clears bit 0 of its target, so only bit 1 can flag it; br/jal check both bits.
  always_comb begin
    redirect          = br_taken | jal | jalr;
    target            = jalr ? ((rs1_data + imm32) & ~32'h1) : (pc_q + imm32);
    target_misaligned = (target[1:0] != 2'b00);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    case (state_q)
      S_LOAD: begin
        pc_d       = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (!stall) begin
          count_d = count_q + 32'd1;
          if (redirect) begin
            if (target_misaligned) begin
              state_d = S_TRAP;
            end else begin
              fetch_pc_d = target;
              state_d    = S_LOAD;
            end
          end else begin
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
      S_TRAP: begin
      end
      default: state_d = S_LOAD;
    endcase
  end

  // While stalled in RUN the ROM re-reads pc so the presented instruction stays put.
  always_comb begin
    imem_addr  = (state_q == S_RUN && stall) ? pc_q[IMEM_ADDR_W+1:2]
                                             : fetch_pc_q[IMEM_ADDR_W+1:2];
    inst_valid = (state_q == S_RUN);
    inst       = (state_q == S_RUN) ? imem_rdata : NOP;
    pc         = pc_q;
    pc_plus4   = pc_q + 32'd4;
    misalign   = (state_q == S_TRAP);
    inst_count = count_q;
  end

endmodule
